uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), which sets the number of clk cycles per UART bit; legal range is at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port uart_rxd, input, 1 bit: the asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits: the last correctly received byte.
REQ-006 The block SHALL have port rx_done, output, 1 bit: one-cycle pulse when rx_data holds a new byte; it drives the FIFO controller's rx_done/wrreq directly.
REQ-007 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port rx_busy, output, 1 bit: high while a frame is being received.

Function
REQ-009 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity: 10 bits total.
REQ-010 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized signal only.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE->START SHALL occur on a detected 1->0 transition of the synchronized line; a line that is already low never starts a frame.
REQ-013 In START, the line SHALL be sampled when the bit counter reaches CLKS_PER_BIT/2 - 1 (integer division): low -> DATA; high -> IDLE (glitch rejected, no outputs pulsed).
REQ-014 In DATA, one bit SHALL be sampled every CLKS_PER_BIT cycles after the start-bit sample and shifted into a shift register LSB first; after the 8th sample -> STOP.
REQ-015 In STOP, the line SHALL be sampled CLKS_PER_BIT cycles after the 8th data sample, then the FSM returns to IDLE on the next cycle.
REQ-016 If the stop sample is 1, rx_data SHALL load the shift register and rx_done SHALL be high for exactly the one cycle following the stop sample.
REQ-017 If the stop sample is 0, frame_err SHALL pulse for one cycle in that same slot, rx_done SHALL stay 0, and rx_data SHALL keep its previous value.
REQ-018 rx_data SHALL hold its value between frames and change only on rx_done.
REQ-019 rx_busy SHALL be high in START, DATA and STOP and low in IDLE.
REQ-020 Because the FSM returns to IDLE at mid-stop-bit, a start edge arriving immediately after the stop bit (back-to-back frames) SHALL be accepted with no lost frame.
REQ-021 The bit counter SHALL be wide enough for CLKS_PER_BIT - 1, SHALL clear on every state change and sample point, and SHALL never wrap.
REQ-022 rx_done and frame_err SHALL never be high in the same cycle, and at most one of them SHALL pulse per frame.

Reset
REQ-023 While reset = 0: state = IDLE, counters = 0, shift register = 0, rx_data = 8'h00, rx_done = 0, frame_err = 0, rx_busy = 0, and both synchronizer flops = 1 (idle).
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_done or frame_err pulse.
REQ-025 After reset release, the next valid falling edge SHALL be received normally.

Verification (CLKS_PER_BIT = 16)
REQ-026 Send 0xA5 with correct framing -> rx_data = 8'hA5, rx_done high exactly 1 cycle, frame_err = 0, rx_busy low after STOP.
REQ-027 Drive uart_rxd low for 4 cycles, then high -> rx_busy returns low, no rx_done, no frame_err, rx_data unchanged.
REQ-028 Send 0x3C with the stop bit forced low -> frame_err pulses 1 cycle, rx_done = 0, rx_data keeps its prior value (8'hA5).
REQ-029 Send 0x00 then 0xFF back-to-back with zero idle time -> two rx_done pulses with rx_data 8'h00 then 8'hFF, no frame_err.
REQ-030 Assert reset during data bit 4 of a frame, release it, then send 0x81 -> no pulse for the aborted frame, rx_data = 8'h00 after reset, then 8'h81 with one rx_done.
REQ-031 Hold uart_rxd low for 30 bit times (break) -> exactly one frame_err, no further activity until the line returns high and a new falling edge occurs.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling, one-cycle
// rx_done / frame_err pulses, and a debug view of the FSM state.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    sync1_d = uart_rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Only a genuine 1->0 edge starts a frame; a line stuck low is ignored.
        if (prev_q && !sync2_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
          cnt_d   = '0;
          state_d = S_IDLE;
          if (sync2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, glitch, frame
// error, back-to-back, mid-frame reset and line break.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;
  logic [1:0] dbg_state;

  int total;
  int bad;

  // Monitor-owned counters; tests work on deltas taken before and after.
  int done_hi;
  int done_pulses;
  int ferr_hi;
  int ferr_pulses;
  int both_cnt;
  int busy_cycles;
  logic done_prev;
  logic ferr_prev;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    done_hi = 0; done_pulses = 0; ferr_hi = 0; ferr_pulses = 0;
    both_cnt = 0; busy_cycles = 0; done_prev = 1'b0; ferr_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (rx_done) begin
      done_hi <= done_hi + 1;
      if (!done_prev) begin
        done_pulses <= done_pulses + 1;
        got_q.push_back(rx_data);
      end
    end
    if (frame_err) begin
      ferr_hi <= ferr_hi + 1;
      if (!ferr_prev) ferr_pulses <= ferr_pulses + 1;
    end
    if (rx_done && frame_err) both_cnt <= both_cnt + 1;
    if (rx_busy) busy_cycles <= busy_cycles + 1;
    done_prev <= rx_done;
    ferr_prev <= frame_err;
  end

  // Driver tasks
  task automatic idle_cycles(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_val);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data got=%h exp=%h", rx_data, 8'h00); bad++; end
    total++; if (rx_done !== 1'b0) begin $display("FAIL reset_rx_done got=%b exp=0", rx_done); bad++; end
    total++; if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err got=%b exp=0", frame_err); bad++; end
    total++; if (rx_busy !== 1'b0) begin $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); bad++; end
    total++; if (dbg_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", dbg_state); bad++; end
    reset = 1'b1;
    idle_cycles(8);
  endtask

  task automatic test_good_frame;
    int d0, dh0, f0, q0;
    d0 = done_pulses; dh0 = done_hi; f0 = ferr_pulses; q0 = got_q.size();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle_cycles(32);
    total++; if (done_pulses - d0 !== 1) begin $display("FAIL a5_done_pulses got=%0d exp=1", done_pulses - d0); bad++; end
    total++; if (done_hi - dh0 !== 1) begin $display("FAIL a5_done_width got=%0d exp=1", done_hi - dh0); bad++; end
    total++; if (ferr_pulses - f0 !== 0) begin $display("FAIL a5_frame_err got=%0d exp=0", ferr_pulses - f0); bad++; end
    total++; if (rx_data !== 8'hA5) begin $display("FAIL a5_rx_data got=%h exp=%h", rx_data, 8'hA5); bad++; end
    total++; if (rx_busy !== 1'b0) begin $display("FAIL a5_busy_after got=%b exp=0", rx_busy); bad++; end
    total++;
    if (got_q.size() != q0 + 1 || got_q[q0] !== exp_q[0]) begin
      $display("FAIL a5_scoreboard got_n=%0d exp_n=%0d", got_q.size() - q0, 1); bad++;
    end
    exp_q.delete();
  endtask

  task automatic test_glitch;
    int d0, f0, b0;
    d0 = done_pulses; f0 = ferr_pulses; b0 = busy_cycles;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle_cycles(40);
    total++; if (busy_cycles - b0 <= 0) begin $display("FAIL glitch_busy_seen got=%0d exp=>0", busy_cycles - b0); bad++; end
    total++; if (rx_busy !== 1'b0) begin $display("FAIL glitch_busy_after got=%b exp=0", rx_busy); bad++; end
    total++; if (done_pulses - d0 !== 0) begin $display("FAIL glitch_done got=%0d exp=0", done_pulses - d0); bad++; end
    total++; if (ferr_pulses - f0 !== 0) begin $display("FAIL glitch_ferr got=%0d exp=0", ferr_pulses - f0); bad++; end
    total++; if (rx_data !== 8'hA5) begin $display("FAIL glitch_rx_data got=%h exp=%h", rx_data, 8'hA5); bad++; end
  endtask

  task automatic test_frame_err;
    int d0, f0, fh0;
    d0 = done_pulses; f0 = ferr_pulses; fh0 = ferr_hi;
    send_byte(8'h3C, 1'b0);
    idle_cycles(32);
    total++; if (ferr_pulses - f0 !== 1) begin $display("FAIL ferr_pulses got=%0d exp=1", ferr_pulses - f0); bad++; end
    total++; if (ferr_hi - fh0 !== 1) begin $display("FAIL ferr_width got=%0d exp=1", ferr_hi - fh0); bad++; end
    total++; if (done_pulses - d0 !== 0) begin $display("FAIL ferr_done got=%0d exp=0", done_pulses - d0); bad++; end
    total++; if (rx_data !== 8'hA5) begin $display("FAIL ferr_rx_data got=%h exp=%h", rx_data, 8'hA5); bad++; end
  endtask

  task automatic test_back_to_back;
    int d0, f0, q0;
    d0 = done_pulses; f0 = ferr_pulses; q0 = got_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle_cycles(32);
    total++; if (done_pulses - d0 !== 2) begin $display("FAIL b2b_done_pulses got=%0d exp=2", done_pulses - d0); bad++; end
    total++; if (ferr_pulses - f0 !== 0) begin $display("FAIL b2b_ferr got=%0d exp=0", ferr_pulses - f0); bad++; end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_q.size() <= q0 + i) begin
        $display("FAIL b2b_byte%0d got=missing exp=%h", i, exp_q[i]); bad++;
      end else if (got_q[q0 + i] !== exp_q[i]) begin
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[q0 + i], exp_q[i]); bad++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort;
    int d0, f0;
    logic [7:0] b;
    b = 8'hF0;
    d0 = done_pulses; f0 = ferr_pulses;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    uart_rxd = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin $display("FAIL abort_rx_data got=%h exp=%h", rx_data, 8'h00); bad++; end
    total++; if (rx_busy !== 1'b0) begin $display("FAIL abort_busy got=%b exp=0", rx_busy); bad++; end
    reset = 1'b1;
    idle_cycles(3 * CPB);
    total++; if (done_pulses - d0 !== 0) begin $display("FAIL abort_done got=%0d exp=0", done_pulses - d0); bad++; end
    total++; if (ferr_pulses - f0 !== 0) begin $display("FAIL abort_ferr got=%0d exp=0", ferr_pulses - f0); bad++; end
    send_byte(8'h81, 1'b1);
    idle_cycles(32);
    total++; if (done_pulses - d0 !== 1) begin $display("FAIL post_reset_done got=%0d exp=1", done_pulses - d0); bad++; end
    total++; if (rx_data !== 8'h81) begin $display("FAIL post_reset_rx_data got=%h exp=%h", rx_data, 8'h81); bad++; end
  endtask

  task automatic test_break;
    int d0, f0, b0;
    d0 = done_pulses; f0 = ferr_pulses;
    uart_rxd = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    total++; if (ferr_pulses - f0 !== 1) begin $display("FAIL break_ferr got=%0d exp=1", ferr_pulses - f0); bad++; end
    total++; if (done_pulses - d0 !== 0) begin $display("FAIL break_done got=%0d exp=0", done_pulses - d0); bad++; end
    total++; if (rx_busy !== 1'b0) begin $display("FAIL break_busy_low got=%b exp=0", rx_busy); bad++; end
    b0 = busy_cycles;
    idle_cycles(32);
    total++; if (busy_cycles - b0 !== 0) begin $display("FAIL break_release_busy got=%0d exp=0", busy_cycles - b0); bad++; end
    send_byte(8'h5A, 1'b1);
    idle_cycles(32);
    total++; if (done_pulses - d0 !== 1) begin $display("FAIL break_recover_done got=%0d exp=1", done_pulses - d0); bad++; end
    total++; if (rx_data !== 8'h5A) begin $display("FAIL break_recover_data got=%h exp=%h", rx_data, 8'h5A); bad++; end
    total++; if (ferr_pulses - f0 !== 1) begin $display("FAIL break_ferr_total got=%0d exp=1", ferr_pulses - f0); bad++; end
  endtask

  // Sequencer and final report
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    uart_rxd = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_break();
    total++; if (both_cnt !== 0) begin $display("FAIL done_and_ferr_overlap got=%0d exp=0", both_cnt); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
